serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing D = A − B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction companion to the team's adder cells. It is intended for area-constrained datapaths where a WIDTH-bit ripple subtractor is too large and WIDTH+1 cycles of latency are acceptable. Operands load through a start/ready handshake; the result is presented on registered outputs with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand and result width in bits; minimum 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- A  in  WIDTH  minuend; sampled on the accepting edge only.
- B  in  WIDTH  subtrahend; sampled on the accepting edge only.
- ready  out  1  high when a start will be accepted.
- done  out  1  one-cycle pulse; D, Bout and V are valid and new.
- D  out  WIDTH  difference (A − B) mod 2^WIDTH.
- Bout  out  1  final borrow; 1 if A < B unsigned.
- V  out  1  signed overflow of A − B, treating operands as two's complement.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- ready = 1 in IDLE and DONE, and 0 in SHIFT.
- Accept: on an edge with start=1 and ready=1:
  - load shift registers a←A and b←B;
  - clear the borrow register and the partial-result register;
  - capture the operand MSBs A[WIDTH-1] and B[WIDTH-1] for the V calculation;
  - set count←0 and go to SHIFT.
- SHIFT, every edge:
  - d = a[0]^b[0]^br;
  - br ← (~a[0]&b[0]) | (~(a[0]^b[0])&br);
  - shift a and b right by one;
  - shift d into the partial-result register from the MSB end, so after WIDTH shifts bit i holds difference bit i;
  - count ← count+1.
- SHIFT exit: the edge that processes bit WIDTH-1 (count = WIDTH-1) also does the following:
  - copy the completed partial result into D;
  - set Bout ← final borrow out of bit WIDTH-1;
  - set V ← (A_msb ≠ B_msb) & (D[WIDTH-1] ≠ A_msb);
  - go to DONE.
- DONE lasts exactly one cycle with done=1, then returns to IDLE, unless start=1 on that edge. In that case the new operands are accepted and the state goes straight to SHIFT (back-to-back).
- start while in SHIFT is ignored and not queued. A and B changing during SHIFT have no effect.
- D, Bout and V change only at the SHIFT exit. They hold their values through IDLE and through any following SHIFT until that operation completes.
- rst=1 on any edge, including mid-SHIFT:
  - state ← IDLE;
  - count, shift registers and borrow ← 0;
  - D ← 0, Bout ← 0, V ← 0, done ← 0;
  - the in-flight operation is discarded with no done pulse.
- rst takes priority over start on the same edge.
- The counter is wide enough to hold WIDTH-1, i.e. $clog2(WIDTH) bits. It does not wrap during operation.

## Timing
- Reset values: ready=1, done=0, D=0, Bout=0, V=0.
- Accepting edge E0. Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
- The state is DONE after edge E_WIDTH. done=1 and the new D/Bout/V are visible in the cycle between E_WIDTH and E_WIDTH+1.
- Latency from the accepting edge to done high: WIDTH cycles.
- Throughput: one operation per WIDTH+1 cycles when start is held high continuously (accept at E0, E_WIDTH+1, ...).
- ready falls the cycle after acceptance and rises in the DONE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, after reset, A=0x5A, B=0x3C, start for 1 cycle:
  - ready=0 for 8 cycles;
  - done for 1 cycle 8 cycles after accept;
  - D=0x1E, Bout=0, V=0.
- A=0x00, B=0x01 → D=0xFF, Bout=1, V=0. Then A=0x80, B=0x01 → D=0x7F, Bout=0, V=1.
- A=0x7F, B=0xFF → D=0x80, Bout=1, V=1. Also check A=B=0xAA → D=0x00, Bout=0, V=0.
- Protected operation:
  - start A=0x10, B=0x01;
  - pulse start with A=0xFF, B=0x00 at cycles 2–5 of SHIFT and toggle A/B;
  - required: single done, D=0x0F, ready stays 0 until the DONE cycle.
- Back-to-back: start held high with A=0x05, B=0x03, then A=0x03, B=0x05 presented in the DONE cycle:
  - done pulses 9 cycles apart;
  - results 0x02 (Bout=0), then 0xFE (Bout=1);
  - D holds 0x02 until the second done.
- Reset mid-SHIFT, asserting rst on cycle 4 of SHIFT:
  - next cycle: ready=1, done=0, D=0, Bout=0, V=0, and no done pulse follows;
  - then A=0x0F, B=0x0E completes normally with D=0x01.
- rst and start on the same edge → no acceptance; ready=1.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;

  modport master (
    output start, A, B,
    input  ready, done, D, Bout, V
  );

  modport slave (
    input  start, A, B,
    output ready, done, D, Bout, V
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B, LSB first, one full-subtractor cell and a registered borrow
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr, b_sr, part;
  logic             br, a_msb, b_msb;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, v_q;
  logic             accept, last;
  logic             d_bit, br_next;

  assign d_bit   = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (count == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // back-to-back: a start in the done cycle skips IDLE entirely
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      part   <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.A;
      b_sr  <= bus.B;
      part  <= '0;
      br    <= 1'b0;
      a_msb <= bus.A[WIDTH-1];
      b_msb <= bus.B[WIDTH-1];
      count <= '0;
    end else if (state_q == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= br_next;
      part <= {d_bit, part[WIDTH-1:1]};
      if (last) begin
        d_q    <= {d_bit, part[WIDTH-1:1]};
        bout_q <= br_next;
        v_q    <= (a_msb != b_msb) & (d_bit != a_msb);
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign bus.ready = (state_q != SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.D     = d_q;
  assign bus.Bout  = bout_q;
  assign bus.V     = v_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed bench with a result scoreboard for serial_subtractor
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             v;
  } result_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   edge_cnt;
  int   done_cnt;
  int   last_done_edge;
  result_t exp_q[$];
  int      acc_q[$];

  serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    result_t r;
    r.d    = a - b;
    r.bout = (a < b);
    r.v    = (a[WIDTH-1] != b[WIDTH-1]) && (r.d[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // One clock: predict acceptance before the edge, check any done pulse after it
  task automatic tick();
    result_t e;
    int      acc_edge;
    if (sif.start && sif.ready && !rst) begin
      exp_q.push_back(model(sif.A, sif.B));
      acc_q.push_back(edge_cnt + 1);
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end
    if (sif.done) begin
      done_cnt++;
      last_done_edge = edge_cnt;
      chk("unexpected_done", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e        = exp_q.pop_front();
        acc_edge = acc_q.pop_front();
        chk("D", sif.D, e.d);
        chk("Bout", sif.Bout, e.bout);
        chk("V", sif.V, e.v);
        chk("latency", edge_cnt - acc_edge, WIDTH);
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!sif.done && n < 40) begin
      tick();
      n++;
    end
    if (!sif.done) chk("timeout", 0, 1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    sif.A     = a;
    sif.B     = b;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    wait_done();
    tick();
  endtask

  initial begin
    int ready_low;
    int dc0;
    int d1;
    clk       = 1'b0;
    rst       = 1'b1;
    checks    = 0;
    errors    = 0;
    edge_cnt  = 0;
    done_cnt  = 0;
    last_done_edge = 0;
    sif.start = 1'b0;
    sif.A     = '0;
    sif.B     = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", sif.ready, 1);
    chk("rst_done", sif.done, 0);
    chk("rst_D", sif.D, 0);
    chk("rst_Bout", sif.Bout, 0);
    chk("rst_V", sif.V, 0);

    // Basic op with ready-low window and single-cycle done
    sif.A = 8'h5A; sif.B = 8'h3C; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    ready_low = 0;
    for (int i = 0; i < 20 && !sif.done; i++) begin
      if (!sif.ready) ready_low++;
      tick();
    end
    chk("ready_low_cycles", ready_low, 8);
    chk("done_seen", sif.done, 1);
    chk("ready_in_done", sif.ready, 1);
    tick();
    chk("done_one_cycle", sif.done, 0);

    run_op(8'h00, 8'h01);
    run_op(8'h80, 8'h01);
    run_op(8'h7F, 8'hFF);
    run_op(8'hAA, 8'hAA);

    // Start pulses and operand churn during SHIFT must be ignored
    dc0 = done_cnt;
    sif.A = 8'h10; sif.B = 8'h01; sif.start = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("prot_ready_low", sif.ready, 0);
      sif.start = (k >= 1 && k <= 4);
      sif.A     = k[0] ? 8'hFF : 8'h00;
      sif.B     = ~sif.A;
      tick();
    end
    sif.start = 1'b0;
    chk("prot_done", sif.done, 1);
    for (int k = 0; k < 12; k++) tick();
    chk("prot_single_done", done_cnt - dc0, 1);

    // Back-to-back with start held high
    sif.A = 8'h05; sif.B = 8'h03; sif.start = 1'b1;
    tick();
    wait_done();
    d1 = last_done_edge;
    sif.A = 8'h03; sif.B = 8'h05;
    tick();
    sif.start = 1'b0;
    for (int k = 0; k < 20 && !sif.done; k++) begin
      chk("b2b_hold_D", sif.D, 8'h02);
      tick();
    end
    chk("b2b_done2", sif.done, 1);
    chk("b2b_spacing", last_done_edge - d1, WIDTH + 1);
    tick();

    // Reset mid-SHIFT discards the operation
    sif.A = 8'h33; sif.B = 8'h11; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", sif.ready, 1);
    chk("mid_rst_done", sif.done, 0);
    chk("mid_rst_D", sif.D, 0);
    chk("mid_rst_Bout", sif.Bout, 0);
    chk("mid_rst_V", sif.V, 0);
    dc0 = done_cnt;
    for (int k = 0; k < 12; k++) tick();
    chk("mid_rst_no_done", done_cnt - dc0, 0);
    run_op(8'h0F, 8'h0E);

    // rst wins over start on the same edge
    dc0 = done_cnt;
    rst = 1'b1; sif.start = 1'b1; sif.A = 8'h44; sif.B = 8'h22;
    tick();
    rst = 1'b0; sif.start = 1'b0;
    chk("rst_start_ready", sif.ready, 1);
    for (int k = 0; k < 12; k++) tick();
    chk("rst_start_no_done", done_cnt - dc0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
